// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed latency, write-back triple straight into the register file.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int unsigned CW = $clog2(ITER);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [2:0]      op;
  logic [4:0]      rd;
  logic            neg_a;
  logic            neg_b;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;

  logic            sa_c, sb_c, neg1_c, neg2_c, accept_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN:0]   div_r_c;
  logic            div_ge_c;
  logic [XLEN-1:0] div_d_c;
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] result_c;

  // Operand decode: sign flags and magnitudes captured at the accepting edge
  always_comb begin
    sa_c = 1'b0;
    sb_c = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin sa_c = 1'b1; sb_c = 1'b1; end
      3'b010:                 sa_c = 1'b1;
      default: ;
    endcase
    neg1_c   = sa_c & rs1_data[XLEN-1];
    neg2_c   = sb_c & rs2_data[XLEN-1];
    mag1_c   = neg1_c ? -rs1_data : rs1_data;
    mag2_c   = neg2_c ? -rs2_data : rs2_data;
    accept_c = start && !flush && (state == IDLE || state == FIN);
  end

  // One iteration step; hi/lo hold {product} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum_c = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : (XLEN+1)'(0));
    div_r_c   = {hi, lo[XLEN-1]};
    div_ge_c  = div_r_c >= {1'b0, opnd};
    div_d_c   = div_ge_c ? XLEN'(div_r_c - {1'b0, opnd}) : div_r_c[XLEN-1:0];
  end

  // Sign fix-up and result selection; divide-by-zero quotient forced to all ones
  always_comb begin
    prod_c   = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    result_c = '0;
    case (op)
      3'b000:                 result_c = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_c = prod_c[PW-1:XLEN];
      3'b100:                 result_c = div_zero ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
      3'b101:                 result_c = lo;
      3'b110:                 result_c = neg_a ? -hi : hi;
      default:                result_c = hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we_out   <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
      op       <= '0;
      rd       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
    end else begin
      done   <= 1'b0;
      we_out <= 1'b0;
      // Completion is already committed in FIN; flush does not cancel it
      if (state == FIN) begin
        done   <= 1'b1;
        we_out <= (rd != 5'd0);
        result <= result_c;
        rd_out <= rd;
      end
      if (accept_c) begin
        state    <= RUN;
        busy     <= 1'b1;
        counter  <= '0;
        op       <= funct3;
        rd       <= rd_in;
        neg_a    <= neg1_c;
        neg_b    <= neg2_c;
        div_zero <= (rs2_data == '0);
        hi       <= '0;
        lo       <= funct3[2] ? mag1_c : mag2_c;
        opnd     <= funct3[2] ? mag2_c : mag1_c;
      end else begin
        case (state)
          RUN: begin
            if (flush) begin
              state   <= IDLE;
              busy    <= 1'b0;
              counter <= '0;
            end else begin
              if (op[2]) begin
                hi <= div_d_c;
                lo <= {lo[XLEN-2:0], div_ge_c};
              end else begin
                hi <= mul_sum_c[XLEN:1];
                lo <= {mul_sum_c[0], lo[XLEN-1:1]};
              end
              counter <= counter + CW'(1);
              if (counter == CW'(ITER - 1)) begin
                state   <= FIN;
                busy    <= 1'b0;
                counter <= '0;
              end
            end
          end
          FIN:     state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;
  int n;
  int cnt;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one start pulse, returns at the negedge after T0
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 80) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    issue(f, a, b, rd);
    chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'd33);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
    chk({tag, "_we"}, 32'(we_out), 32'(rd != 5'd0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we_out), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);

    // Reset in the middle of a multiply
    issue(3'b000, 32'd3, 32'd4, 5'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    count_done(40, cnt);
    chk("midrst_nodone", 32'(cnt), 32'd0);
    chk("midrst_res", result, 32'd0);
    chk("midrst_rd", 32'(rd_out), 32'd0);
    chk("midrst_we", 32'(we_out), 32'd0);

    // Multiplies
    run("mul",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001);
    chk("mul_busy_done", 32'(busy), 32'd0);
    run("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd5, 32'hFFFFFFFF);
    run("mul_big", 3'b000, 32'h12345678, 32'h00010000, 5'd8, 32'h56780000);
    run("mulhu_big", 3'b011, 32'h12345678, 32'h00010000, 5'd8, 32'h00001234);

    // Divides
    run("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD);
    run("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    run("divu",     3'b101, 32'd100, 32'd7, 5'd6, 32'd14);
    run("remu",     3'b111, 32'd100, 32'd7, 5'd6, 32'd2);
    run("div_negb", 3'b100, 32'd7, 32'hFFFFFFFE, 5'd6, 32'hFFFFFFFD);
    run("rem_negb", 3'b110, 32'd7, 32'hFFFFFFFE, 5'd6, 32'd1);

    // Special cases
    run("div_z",   3'b100, 32'd5, 32'd0, 5'd2, 32'hFFFFFFFF);
    run("divn_z",  3'b100, 32'hFFFFFFFB, 32'd0, 5'd2, 32'hFFFFFFFF);
    run("remu_z",  3'b111, 32'd5, 32'd0, 5'd2, 32'd5);
    run("rem_z",   3'b110, 32'hFFFFFFFB, 32'd0, 5'd2, 32'hFFFFFFFB);
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000);
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h00000000);

    // Start while busy is ignored
    issue(3'b000, 32'd3, 32'd4, 5'd7);
    repeat (4) @(negedge clk);
    issue(3'b000, 32'd5, 32'd5, 5'd9);
    wait_done(n);
    chk("ign_lat", 32'(n), 32'd28);
    chk("ign_res", result, 32'd12);
    chk("ign_rd", 32'(rd_out), 32'd7);
    count_done(40, cnt);
    chk("ign_nodone", 32'(cnt), 32'd0);

    // Back-to-back issue from the FIN cycle
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    repeat (32) @(negedge clk);
    chk("b2b_fin_busy", 32'(busy), 32'd0);
    chk("b2b_fin_done", 32'(done), 32'd0);
    issue(3'b101, 32'd100, 32'd7, 5'd4);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_res1", result, 32'hFFFFFFFE);
    chk("b2b_rd1", 32'(rd_out), 32'd3);
    chk("b2b_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    wait_done(n);
    chk("b2b_lat2", 32'(n + 1), 32'd33);
    chk("b2b_res2", result, 32'd14);
    chk("b2b_rd2", 32'(rd_out), 32'd4);

    // rd = x0: done pulses but no write enable
    run("rd0", 3'b101, 32'd100, 32'd7, 5'd0, 32'd14);
    chk("rd0_done", 32'(done), 32'd1);

    // Flush mid-run, then a fresh multiply
    issue(3'b000, 32'd3, 32'd4, 5'd6);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    count_done(40, cnt);
    chk("flush_nodone", 32'(cnt), 32'd0);
    run("post_flush", 3'b000, 32'd6, 32'd7, 5'd6, 32'd42);

    // Flush together with start in IDLE drops the start
    flush = 1'b1;
    issue(3'b000, 32'd9, 32'd9, 5'd1);
    flush = 1'b0;
    chk("fs_busy", 32'(busy), 32'd0);
    count_done(40, cnt);
    chk("fs_nodone", 32'(cnt), 32'd0);
    chk("fs_res", result, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
